// File: rtl/wb_regfile_if.sv
// Writeback-stage bus: MEM/WB inputs, decode read ports and the commit trace.
// The pipeline side drives through master; the register file sits on slave.
interface wb_regfile_if #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
);
    logic [XLEN-1:0]     pc_i;
    logic [INST_LEN-1:0] instr_i;
    logic [XLEN-1:0]     alures_i;
    logic [XLEN-1:0]     lsres_i;
    logic                wben_i;
    logic [4:0]          rs1_addr_i;
    logic [4:0]          rs2_addr_i;
    logic [XLEN-1:0]     rs1_data_o;
    logic [XLEN-1:0]     rs2_data_o;
    logic                commit_valid_o;
    logic [XLEN-1:0]     commit_pc_o;
    logic [INST_LEN-1:0] commit_instr_o;
    logic [XLEN-1:0]     commit_wdata_o;
    logic [63:0]         instret_o;
    logic                halt_o;
    logic [XLEN-1:0]     halt_code_o;

    modport master (
        output pc_i, instr_i, alures_i, lsres_i, wben_i, rs1_addr_i, rs2_addr_i,
        input  rs1_data_o, rs2_data_o, commit_valid_o, commit_pc_o, commit_instr_o,
               commit_wdata_o, instret_o, halt_o, halt_code_o
    );

    modport slave (
        input  pc_i, instr_i, alures_i, lsres_i, wben_i, rs1_addr_i, rs2_addr_i,
        output rs1_data_o, rs2_data_o, commit_valid_o, commit_pc_o, commit_instr_o,
               commit_wdata_o, instret_o, halt_o, halt_code_o
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result, commits it to a 32-entry register file with
// bypassed read ports, and emits the commit trace, retired count and ebreak halt.
module wb_regfile #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    localparam logic [6:0]          OPC_LOAD = 7'b0000011;
    localparam logic [INST_LEN-1:0] EBREAK   = INST_LEN'(32'h00100073);

    logic                valid;
    logic                active;
    logic                we;
    logic                is_ebreak;
    logic [4:0]          rd;
    logic [XLEN-1:0]     wdata;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;

    logic [XLEN-1:0]     regs_q [32];
    logic [XLEN-1:0]     regs_d [32];
    logic                commit_valid_q, commit_valid_d;
    logic [XLEN-1:0]     commit_pc_q, commit_pc_d;
    logic [INST_LEN-1:0] commit_instr_q, commit_instr_d;
    logic [XLEN-1:0]     commit_wdata_q, commit_wdata_d;
    logic [63:0]         instret_q, instret_d;
    logic                halt_q, halt_d;
    logic [XLEN-1:0]     halt_code_q, halt_code_d;

    // Decode of the instruction sitting in WB; once halted nothing is active.
    always_comb begin
        valid     = |bus.instr_i;
        active    = valid & ~halt_q;
        rd        = bus.instr_i[11:7];
        wdata     = (bus.instr_i[6:0] == OPC_LOAD) ? bus.lsres_i : bus.alures_i;
        we        = bus.wben_i & active & (rd != 5'd0);
        is_ebreak = active & (bus.instr_i == EBREAK);
    end

    // Read ports see the write of this same cycle so decode never reads stale data.
    always_comb begin
        rs1_data = regs_q[bus.rs1_addr_i];
        rs2_data = regs_q[bus.rs2_addr_i];
        if (bus.rs1_addr_i == 5'd0)              rs1_data = '0;
        else if (we && bus.rs1_addr_i == rd)     rs1_data = wdata;
        if (bus.rs2_addr_i == 5'd0)              rs2_data = '0;
        else if (we && bus.rs2_addr_i == rd)     rs2_data = wdata;
    end

    // NOTE: every next-state signal gets its default first so no latch is inferred;
    // combinational blocks use blocking '=', only the always_ff uses '<='.
    always_comb begin
        regs_d         = regs_q;
        commit_valid_d = active;
        commit_pc_d    = commit_pc_q;
        commit_instr_d = commit_instr_q;
        commit_wdata_d = commit_wdata_q;
        instret_d      = instret_q;
        halt_d         = halt_q | is_ebreak;
        halt_code_d    = halt_code_q;
        if (we) regs_d[rd] = wdata;
        if (active) begin
            commit_pc_d    = bus.pc_i;
            commit_instr_d = bus.instr_i;
            commit_wdata_d = we ? wdata : '0;
            instret_d      = instret_q + 64'd1;
        end
        // ebreak has rd=0, so x10 in storage is already the architectural value.
        if (is_ebreak) halt_code_d = regs_q[10];
    end

    // NOTE: the register array is reset like ordinary flops because software relies on
    // every register reading zero after reset; this rules out an SRAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_instr_q <= '0;
            commit_wdata_q <= '0;
            instret_q      <= '0;
            halt_q         <= 1'b0;
            halt_code_q    <= '0;
        end else begin
            regs_q         <= regs_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_instr_q <= commit_instr_d;
            commit_wdata_q <= commit_wdata_d;
            instret_q      <= instret_d;
            halt_q         <= halt_d;
            halt_code_q    <= halt_code_d;
        end
    end

    assign bus.rs1_data_o     = rs1_data;
    assign bus.rs2_data_o     = rs2_data;
    assign bus.commit_valid_o = commit_valid_q;
    assign bus.commit_pc_o    = commit_pc_q;
    assign bus.commit_instr_o = commit_instr_q;
    assign bus.commit_wdata_o = commit_wdata_q;
    assign bus.instret_o      = instret_q;
    assign bus.halt_o         = halt_q;
    assign bus.halt_code_o    = halt_code_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomised bench for wb_regfile: an architectural model predicts reads and commits;
// commit records go through a scoreboard queue drained by an independent monitor.
module tb_wb_regfile;
    localparam int XLEN = 64;
    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [6:0]  OP_LD  = 7'b0000011;

    typedef logic [63:0] word_t;
    typedef struct {
        word_t       pc;
        logic [31:0] instr;
        word_t       wdata;
    } commit_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if #(.XLEN(XLEN), .INST_LEN(32)) bus ();

    wb_regfile #(.XLEN(XLEN), .INST_LEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Architectural state as software sees it.
    word_t   mdl_regs [32];
    bit      mdl_halted;
    word_t   mdl_instret;
    word_t   mdl_halt_code;
    commit_t sb_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < 32; i++) mdl_regs[i] = '0;
        mdl_halted    = 1'b0;
        mdl_instret   = '0;
        mdl_halt_code = '0;
        sb_q.delete();
    endfunction

    // Newest architectural value of a register as seen while (we, rd, wd) is in WB.
    function automatic word_t mdl_read(input logic [4:0] addr, input bit we,
                                       input logic [4:0] rd, input word_t wd);
        if (addr == 5'd0)          return '0;
        if (we && addr == rd)      return wd;
        return mdl_regs[addr];
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd);
        return {20'h00000, rd, opc};
    endfunction

    // One WB cycle: present inputs after the falling edge, check reads, retire in the model.
    task automatic drive(input word_t pc, input logic [31:0] instr, input word_t alu,
                         input word_t ls, input logic wben,
                         input logic [4:0] a1, input logic [4:0] a2);
        bit          live, we;
        logic [4:0]  rd;
        word_t       wd;
        @(negedge clk);
        bus.pc_i       = pc;
        bus.instr_i    = instr;
        bus.alures_i   = alu;
        bus.lsres_i    = ls;
        bus.wben_i     = wben;
        bus.rs1_addr_i = a1;
        bus.rs2_addr_i = a2;
        live = (instr != 32'd0) && !mdl_halted;
        rd   = instr[11:7];
        wd   = (instr[6:0] == OP_LD) ? ls : alu;
        we   = wben && live && (rd != 5'd0);
        #1;
        check("rs1_data", bus.rs1_data_o, mdl_read(a1, we, rd, wd));
        check("rs2_data", bus.rs2_data_o, mdl_read(a2, we, rd, wd));
        @(posedge clk);
        if (rst_n && live) begin
            mdl_instret++;
            sb_q.push_back('{pc: pc, instr: instr, wdata: we ? wd : '0});
            if (instr == EBREAK) begin
                mdl_halted    = 1'b1;
                mdl_halt_code = mdl_regs[10];
            end
            if (we) mdl_regs[rd] = wd;
        end
    endtask

    task automatic bubble(input logic [4:0] a1, input logic [4:0] a2);
        drive('0, 32'd0, '0, '0, 1'b0, a1, a2);
    endtask

    task automatic random_instr(input bit allow_bubble);
        logic [31:0] r;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  a1, a2;
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       opc = OP_IMM;
            1:       opc = OP_LD;
            2:       opc = 7'b0110011;
            default: opc = 7'b0100011;
        endcase
        rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
        a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
        if (allow_bubble && $urandom_range(0, 5) == 0)
            bubble(a1, a2);
        else
            drive({$urandom(), $urandom()}, {r[31:12], rd, opc}, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, 1'($urandom_range(0, 3) != 0), a1, a2);
    endtask

    // Monitor: pops one scoreboard record per commit pulse and tracks count and halt.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("commit_valid", 64'(bus.commit_valid_o), 64'(sb_q.size() != 0));
            if (bus.commit_valid_o && sb_q.size() != 0) begin
                commit_t e;
                e = sb_q.pop_front();
                check("commit_pc", bus.commit_pc_o, e.pc);
                check("commit_instr", 64'(bus.commit_instr_o), 64'(e.instr));
                check("commit_wdata", bus.commit_wdata_o, e.wdata);
            end
            check("instret", bus.instret_o, mdl_instret);
            check("halt", 64'(bus.halt_o), 64'(mdl_halted));
            check("halt_code", bus.halt_code_o, mdl_halt_code);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.pc_i = '0; bus.instr_i = '0; bus.alures_i = '0; bus.lsres_i = '0;
        bus.wben_i = 1'b0; bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
        mdl_reset();
        #12;
        check("rst_commit_valid", 64'(bus.commit_valid_o), 64'd0);
        check("rst_commit_pc", bus.commit_pc_o, 64'd0);
        check("rst_commit_instr", 64'(bus.commit_instr_o), 64'd0);
        check("rst_commit_wdata", bus.commit_wdata_o, 64'd0);
        check("rst_instret", bus.instret_o, 64'd0);
        check("rst_halt", 64'(bus.halt_o), 64'd0);
        check("rst_halt_code", bus.halt_code_o, 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 32; i++) bubble(5'(i), 5'(31 - i));

        drive(64'h100, mk(OP_IMM, 5), 64'h1234, 64'h0, 1'b1, 5'd5, 5'd0);
        bubble(5'd5, 5'd5);
        drive(64'h104, mk(OP_LD, 6), 64'hAAAA, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 5'd6, 5'd5);
        bubble(5'd6, 5'd0);
        drive(64'h108, mk(OP_IMM, 0), 64'hDEAD, 64'h0, 1'b1, 5'd0, 5'd0);
        drive(64'h10C, mk(OP_IMM, 10), 64'h2A, 64'h0, 1'b1, 5'd10, 5'd6);
        drive(64'h110, EBREAK, 64'h5555, 64'h0, 1'b1, 5'd10, 5'd10);
        drive(64'h114, mk(OP_IMM, 7), 64'h99, 64'h0, 1'b1, 5'd7, 5'd7);
        bubble(5'd7, 5'd10);
        @(negedge clk); #1;
        check("dir_halt", 64'(bus.halt_o), 64'd1);
        check("dir_halt_code", bus.halt_code_o, 64'h2A);
        check("dir_instret", bus.instret_o, 64'd5);

        // Reset pulse of half a cycle straddling the edge that would store x3.
        @(negedge clk);
        bus.pc_i = 64'h200; bus.instr_i = mk(OP_IMM, 3); bus.alures_i = 64'h3333;
        bus.wben_i = 1'b1; bus.rs1_addr_i = 5'd3;
        #2 rst_n = 1'b0;
        mdl_reset();
        #1;
        check("mid_rst_instret", bus.instret_o, 64'd0);
        check("mid_rst_halt", 64'(bus.halt_o), 64'd0);
        check("mid_rst_commit_valid", 64'(bus.commit_valid_o), 64'd0);
        #4 rst_n = 1'b1;
        bus.instr_i = '0; bus.wben_i = 1'b0;
        bubble(5'd3, 5'd10);
        drive(64'h204, mk(OP_IMM, 3), 64'h77, 64'h0, 1'b1, 5'd3, 5'd0);
        bubble(5'd3, 5'd7);

        for (int i = 0; i < 600; i++) random_instr(1'b1);

        drive(64'h300, mk(OP_IMM, 10), {$urandom(), $urandom()}, 64'h0, 1'b1, 5'd10, 5'd0);
        drive(64'h304, EBREAK, 64'h1, 64'h2, 1'b1, 5'd10, 5'd0);
        for (int i = 0; i < 8; i++) random_instr(1'b0);
        bubble(5'd0, 5'd0);
        bubble(5'd0, 5'd0);
        @(negedge clk); #1;
        check("final_halt", 64'(bus.halt_o), 64'd1);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
